// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready skid buffer with registered in_ready/out_valid and a sticky upstream protocol flag.
// Optional immediate assertions are compiled in when STREAM_SKID_IMM_ASSERT_EN is defined.
module stream_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic             proto_err
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] data_p0;
  logic             stall_p0;
  logic             accept;
  logic             pop;

  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign occupancy = state;
  assign out_data  = main_data;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !pop)      state_nxt = FULL;
        else if (pop && !accept) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Control: in_ready/out_valid are registered from the next state, so out_ready never reaches in_ready combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      stall_p0  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != FULL);
      out_valid <= (state_nxt != EMPTY);
      stall_p0  <= in_valid & ~in_ready;
      if (stall_p0 && (!in_valid || in_data != data_p0))
        proto_err <= 1'b1;
    end
  end

  // Data path: no reset, contents only meaningful while the matching entry is valid
  always_ff @(posedge clk) begin
    data_p0 <= in_data;
    case (state)
      EMPTY: if (accept) main_data <= in_data;
      ONE: begin
        if (accept && pop)  main_data <= in_data;
        if (accept && !pop) skid_data <= in_data;
      end
      FULL:    if (pop) main_data <= skid_data;
      default: ;
    endcase
  end

`ifdef STREAM_SKID_IMM_ASSERT_EN
  always @(posedge clk) begin
    if (rst_n) begin
      assert final (occupancy != 2'd3) else $error("occupancy illegal");
      assert final (out_valid == (occupancy != 0)) else $error("out_valid inconsistent");
      assert final (in_ready == (occupancy != 2)) else $error("in_ready inconsistent");
      assume final (!stall_p0 || (in_valid && in_data == data_p0)) else $error("upstream unstable while stalled");
      cover #0 (occupancy == 2 && out_ready) $display("skid drain");
    end
  end
`endif

endmodule

// File: tb/tb_stream_skid_buffer.sv
// Bench for stream_skid_buffer: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_stream_skid_buffer;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic             proto_err;

  int checks   = 0;
  int failures = 0;

  // reference model: a FIFO of held beats plus the registered-ready and sticky-error rules
  logic [WIDTH-1:0] q[$];
  logic             m_rdy;
  logic             m_err;
  logic             m_stall;
  logic [WIDTH-1:0] m_pdata;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       ov;
    logic [7:0] od;
    logic [1:0] occ;
    logic       ir;
  } vec_t;
  vec_t tbl[11];

  always #5 clk = ~clk;

  stream_skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .proto_err(proto_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rdy = 1'b0; m_err = 1'b0; m_stall = 1'b0; m_pdata = '0;
  endtask

  task automatic model_check();
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
    chk("m_occupancy", {30'd0, occupancy}, q.size());
    chk("m_in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
    chk("m_proto_err", {31'd0, proto_err}, {31'd0, m_err});
    if (q.size() != 0) chk("m_out_data", {24'd0, out_data}, {24'd0, q[0]});
  endtask

  task automatic model_step();
    logic acc, pp;
    acc = in_valid & m_rdy;
    pp  = (q.size() != 0) & out_ready;
    if (m_stall && (!in_valid || in_data != m_pdata)) m_err = 1'b1;
    m_stall = in_valid & ~m_rdy;
    m_pdata = in_data;
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(in_data);
    m_rdy = (q.size() < 2);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    in_valid = v; in_data = d; out_ready = r;
    #1;
  endtask

  task automatic fin();
    model_check();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    drive(v, d, r);
    fin();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 2'd1, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[3]  = '{1'b1, 8'hA0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[4]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 8'hA0, 2'd1, 1'b1};
    tbl[5]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 8'hA0, 2'd2, 1'b0};
    tbl[6]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 8'hA0, 2'd2, 1'b0};
    tbl[7]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 8'hA0, 2'd2, 1'b0};
    tbl[8]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 8'hA1, 2'd1, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA2, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};

    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;

    // reset / idle
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
      chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
    end
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    chk("rel_in_ready_first", {31'd0, in_ready}, 32'd0);
    fin();
    drive(1'b0, 8'h00, 1'b1);
    chk("rel_in_ready_next", {31'd0, in_ready}, 32'd1);
    fin();

    // single beat and backpressure vectors
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
      chk($sformatf("tbl%0d_occupancy", i), {30'd0, occupancy}, {30'd0, tbl[i].occ});
      chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].ir});
      chk($sformatf("tbl%0d_proto_err", i), {31'd0, proto_err}, 32'd0);
      if (tbl[i].ov) chk($sformatf("tbl%0d_out_data", i), {24'd0, out_data}, {24'd0, tbl[i].od});
      fin();
    end

    // streaming 16 beats back-to-back
    for (int i = 0; i <= 16; i++) begin
      drive(i < 16, 8'(i), 1'b1);
      if (i > 0) begin
        chk("stream_data", {24'd0, out_data}, i - 1);
        chk("stream_occ", {30'd0, occupancy}, 32'd1);
        chk("stream_valid", {31'd0, out_valid}, 32'd1);
      end
      fin();
    end
    cyc(1'b0, 8'h00, 1'b1);

    // protocol violation while FULL
    cyc(1'b1, 8'h54, 1'b0);
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'h56, 1'b0);
    chk("perr_before", {31'd0, proto_err}, 32'd0);
    fin();
    drive(1'b1, 8'h56, 1'b1);
    chk("perr_set", {31'd0, proto_err}, 32'd1);
    fin();
    cyc(1'b1, 8'h56, 1'b1);
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    chk("perr_hold", {31'd0, proto_err}, 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("perr_cleared", {31'd0, proto_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);

    // reset while FULL
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("full_before_rst", {30'd0, occupancy}, 32'd2);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_async_occ", {30'd0, occupancy}, 32'd0);
    chk("rst_async_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      drive(1'b0, 8'h00, 1'b1);
      chk("no_stale_beat", {31'd0, out_valid}, 32'd0);
      fin();
    end

    // randomized compliant traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic       v, r;
      logic [7:0] d;
      if (m_stall) begin
        v = in_valid;
        d = in_data;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        d = 8'($urandom);
      end
      r = ($urandom_range(0, 2) != 0);
      cyc(v, d, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_skid_buffer.md
# stream_skid_buffer

Two-entry valid/ready skid buffer that registers a data stream at full throughput and breaks the combinational ready path. It sits directly upstream of the immediate-assertion testbench checkers and drives their `data0`-style inputs. It also flags upstream handshake violations and carries its own immediate assertions for the checker stage to exercise.

## Interface
- `WIDTH`, default 8: payload width in bits.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  buffer can accept; registered, depends only on state.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  downstream beat present; registered.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  downstream payload, driven from the main register.
- `occupancy`  out  2  entries held: 0, 1 or 2.
- `proto_err`  out  1  sticky upstream protocol-violation flag.

## Operation
- Handshakes: accept = `in_valid & in_ready`; pop = `out_valid & out_ready`.
- Storage: main register (M) feeds `out_data`; skid register (S) is used only in FULL.
- States and transitions:
  - EMPTY (occ 0, `in_ready`=1, `out_valid`=0):
    - accept → ONE, M ← `in_data`.
  - ONE (occ 1, `in_ready`=1, `out_valid`=1):
    - accept & pop → ONE, M ← `in_data`.
    - accept & !pop → FULL, S ← `in_data`.
    - pop & !accept → EMPTY.
    - neither → hold.
  - FULL (occ 2, `in_ready`=0, `out_valid`=1):
    - pop → ONE, M ← S.
    - no pop → hold.
    - `in_valid` is ignored in FULL.
- Ordering: strictly FIFO; no beat is dropped or duplicated.
- `proto_err` is set on the rising edge after a cycle with `in_valid`=1 and `in_ready`=0 if, in the current cycle:
  - `in_valid` is 0, or
  - `in_data` differs from the previous cycle.
- `proto_err` clears only on reset.
- Data registers are not reset; their contents are don't-care while the corresponding entry is invalid.

## Timing
- Reset, asynchronous, while `rst_n`=0:
  - state EMPTY, `in_ready`=0, `out_valid`=0, `occupancy`=0, `proto_err`=0.
  - `out_data` is undefined.
- First rising edge after deassertion: `in_ready`=1.
- Latency: a beat accepted at edge N is visible on `out_data`/`out_valid` after edge N (cycle N+1) when the buffer was EMPTY.
- Throughput: one beat per cycle sustained while `out_ready`=1.
- Backpressure:
  - `out_ready` low for one cycle in ONE with input streaming → FULL.
  - `in_ready` drops the following cycle.
  - No combinational path from `out_ready` to `in_ready`.
- Simultaneous accept and pop in ONE keeps occupancy at 1 with no bubble.
- Reset mid-operation discards all held beats immediately. Outputs go to their reset values asynchronously, not at the next edge.
- `occupancy` is the binary state encoding; value 3 is illegal.

## Configuration
- Macro: `STREAM_SKID_IMM_ASSERT_EN`.
- When defined, the RTL contains these immediate assertions in an `always @(posedge clk)` block, gated by `rst_n`:
  - `assert final (occupancy != 2'd3) else $error`.
  - `assert final (out_valid == (occupancy != 0)) else $error`.
  - `assert final (in_ready == (occupancy != 2)) else $error`.
  - `assume final` on upstream stability: `in_valid` held and `in_data` stable while stalled.
  - `cover #0 (occupancy == 2 && out_ready)` with `$display("skid drain")`.
- When undefined, none of these statements exist.
- Functional behaviour, including `proto_err`, is identical in both builds.

## Test plan
- Reset/idle: hold `rst_n`=0 for 3 cycles, then release → `in_ready`=0 during reset and 1 one cycle after; `out_valid`=0; `occupancy`=0.
- Single beat: `in_data`=0x01 with `in_valid` for 1 cycle, `out_ready`=1 → `out_data`=0x01, `out_valid`=1 for exactly one cycle, next cycle after accept.
- Streaming: 16 beats 0x00..0x0F back-to-back with `out_ready`=1 → output in order, one per cycle, `occupancy` stays 1.
- Backpressure: stream 0xA0, 0xA1, 0xA2 with `out_ready`=0 from the second beat → `occupancy`=2 and `in_ready`=0. Restore `out_ready` → output 0xA0, 0xA1, 0xA2 in order; the third beat is accepted only after `in_ready` returns to 1.
- Protocol violation: in FULL, change `in_data` 0x55 → 0x56 while `in_valid`=1 → `proto_err`=1 next edge and stays 1 until `rst_n` is pulsed.
- Reset mid-FULL: assert `rst_n`=0 with 2 entries held → `out_valid`=0 and `occupancy`=0 immediately. After release, no stale beat ever appears.
